// File: rtl/prio_enc_rr_pkg.sv
// Shared definitions for the round-robin / fixed priority encoder:
// mode encodings and the index-width helper.
package prio_enc_rr_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Width of a binary index into n request lines (never below one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_enc_rr_pick.sv
// Combinational winner search: highest set bit in fixed mode, first set bit
// at or above ptr (wrapping) in round-robin mode.
module prio_pick
    import prio_enc_rr_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  mode_e        mode,
    output logic [W-1:0] winner,
    output logic         any
);

    always_comb begin
        int   j;
        logic found;
        winner = '0;
        any    = |req;
        found  = 1'b0;
        j      = 0;
        if (mode == MODE_RR) begin
            // Walk N positions starting at ptr; the first hit is the winner.
            for (int i = 0; i < N; i++) begin
                j = int'(ptr) + i;
                if (j >= N) begin
                    j = j - N;
                end
                if (!found && req[j[W-1:0]]) begin
                    winner = W'(j);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    winner = W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered priority encoder with valid/ready output and selectable
// fixed or round-robin arbitration.
module prio_enc_rr
    import prio_enc_rr_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enb,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant,
    output logic         none
);

    // Handshake: a result is consumed on any cycle with out_valid=1 and
    // out_ready=1; a new vector is captured when enb=1 and the output slot
    // is empty or being consumed in the same cycle.

    logic         valid_q;
    logic [W-1:0] idx_q;
    logic [N-1:0] grant_q;
    logic         none_q;
    logic [W-1:0] ptr_q;

    logic         accept;
    logic         pop;
    logic [W-1:0] winner;
    logic         any;
    logic [W-1:0] ptr_d;
    mode_e        mode_sel;

    assign mode_sel = mode_e'(mode);
    assign accept   = enb && (!valid_q || out_ready);
    assign pop      = valid_q && out_ready;
    assign ptr_d    = (winner == W'(N - 1)) ? '0 : winner + W'(1);

    prio_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .mode   (mode_sel),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            grant_q <= '0;
            none_q  <= 1'b0;
            ptr_q   <= '0;
        end else if (accept) begin
            if (any) begin
                valid_q <= 1'b1;
                idx_q   <= winner;
                grant_q <= N'(1) << winner;
                none_q  <= 1'b0;
                if (mode_sel == MODE_RR) begin
                    ptr_q <= ptr_d;
                end
            end else begin
                // Empty vector: idx keeps the last winner for reference.
                valid_q <= 1'b0;
                grant_q <= '0;
                none_q  <= 1'b1;
            end
        end else if (pop) begin
            valid_q <= 1'b0;
            grant_q <= '0;
        end
    end

    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign grant     = grant_q;
    assign none      = none_q;

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
- REQ-001: Parameter N, default 8, SHALL set the number of request inputs, legal range 2..64.
- REQ-002: Parameter W, default $clog2(N), SHALL set the index width and SHALL be derived from N, not overridden.
- REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  SHALL be the asynchronous, active-low reset.
- REQ-005: enb  input  1  SHALL be the encode enable; when low, no new request vector is captured.
- REQ-006: mode  input  1  SHALL select priority: 0 = fixed (highest index wins), 1 = round-robin.
- REQ-007: req  input  N  SHALL carry the request vector, any number of bits set.
- REQ-008: out_ready  input  1  SHALL indicate the consumer accepts the current result.
- REQ-009: out_valid  output  1  SHALL indicate idx/grant hold a valid encoded result.
- REQ-010: idx  output  W  SHALL carry the binary index of the winning request.
- REQ-011: grant  output  N  SHALL carry the one-hot form of idx, or 0 when out_valid=0.
- REQ-012: none  output  1  SHALL flag that the last captured vector had no bits set.

Function
- REQ-013: Accept condition SHALL be enb=1 AND (out_valid=0 OR out_ready=1), evaluated each cycle.
- REQ-014: On accept with req!=0, the winner SHALL be registered: out_valid=1, idx=winner, grant=1<<winner, none=0; latency exactly 1 cycle.
- REQ-015: On accept with req==0: out_valid=0, grant=0, none=1; idx holds its previous value.
- REQ-016: mode=0 SHALL select the highest set bit of req (bit N-1 highest priority).
- REQ-017: mode=1 SHALL select the first set bit found searching upward from pointer ptr, wrapping from N-1 to 0.
- REQ-018: ptr SHALL be an internal W-bit register, updated only on a mode=1 accept with req!=0, to (winner+1) mod N, including N not a power of two.
- REQ-019: mode=0 accepts SHALL leave ptr unchanged; switching mode SHALL NOT alter ptr.
- REQ-020: When out_valid=1 and out_ready=0 (stall), out_valid, idx, grant, none and ptr SHALL hold; req changes ignored.
- REQ-021: When enb=0 and out_valid=1 and out_ready=1, out_valid SHALL clear to 0, grant to 0 next cycle; idx, none, ptr hold.
- REQ-022: When enb=0 and no handshake occurs, all registers SHALL hold.
- REQ-023: Outputs SHALL be driven only from registers; no combinational path from req, mode or enb to any output.

Reset
- REQ-024: rst_n=0 SHALL immediately, without a clock edge, force out_valid=0, idx=0, grant=0, none=0, ptr=0.
- REQ-025: Reset asserted mid-stall SHALL discard the held result; the first accept after release SHALL use ptr=0.
- REQ-026: Release of rst_n SHALL be synchronised externally; the block takes no further action.

Structure
- REQ-027: A shared package SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the index-width helper function.
- REQ-028: A combinational sub-module prio_pick (inputs req, ptr, mode; outputs winner, any) SHALL implement the search; prio_enc_rr holds all registers and handshake logic.

Verification (N=8)
- REQ-029: Reset: drive rst_n=0 while out_valid=1 mid-cycle -> all outputs 0 before the next edge; after release with mode=1, req=8'hFF -> first idx=0.
- REQ-030: Fixed: mode=0, enb=1, out_ready=1, req=8'b1000_0001 -> next cycle out_valid=1, idx=7, grant=8'h80; req=8'b0000_0110 -> idx=2.
- REQ-031: Round-robin: mode=1, req=8'hFF held, out_ready=1 -> idx sequence 0,1,2,...,7,0 on consecutive cycles.
- REQ-032: Round-robin sparse: mode=1, ptr=0, req=8'b0010_0100 held -> idx 2, 5, 2, 5.
- REQ-033: Backpressure: out_valid=1, idx=3, out_ready=0 for 4 cycles while req changes -> idx=3 and ptr hold; out_ready=1 -> next result uses the unchanged ptr.
- REQ-034: Empty/disable: enb=1, req=0 -> out_valid=0, none=1; then enb=0, req=8'h10 -> no change for 3 cycles.
